// File: rtl/pipelined_cla_adder_if.sv
// Valid/ready bundle for pipelined_cla_adder: operand side from the producer,
// result/flag side to the consumer.
interface pipelined_cla_adder_if #(
  parameter int NUMBITS = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [NUMBITS-1:0] A;
  logic [NUMBITS-1:0] B;
  logic               carryin;
  logic               sub;
  logic               out_valid;
  logic               out_ready;
  logic [NUMBITS-1:0] result;
  logic               carryout;
  logic               overflow;
  logic               zero;

  modport master (
    output in_valid, A, B, carryin, sub, out_ready,
    input  in_ready, out_valid, result, carryout, overflow, zero
  );

  modport slave (
    input  in_valid, A, B, carryin, sub, out_ready,
    output in_ready, out_valid, result, carryout, overflow, zero
  );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one SEGBITS segment per stage,
// 4-bit lookahead groups inside a segment, carry registered between stages.
module pipelined_cla_adder #(
  parameter int NUMBITS = 32,
  parameter int SEGBITS = 8
) (
  input logic                  clk,
  input logic                  reset,
  pipelined_cla_adder_if.slave bus
);
  localparam int NUM_SEG = NUMBITS / SEGBITS;
  localparam int NUM_GRP = SEGBITS / 4;

  if (((NUMBITS % SEGBITS) != 0) || ((SEGBITS % 4) != 0)) begin : g_param_check
    $error("pipelined_cla_adder: NUMBITS must be a multiple of SEGBITS and SEGBITS a multiple of 4");
  end

  // Returns {carry_out, sum} for one segment; groups of 4 bits use full lookahead.
  function automatic logic [SEGBITS:0] cla_seg(input logic [SEGBITS-1:0] a,
                                               input logic [SEGBITS-1:0] b,
                                               input logic               cin);
    logic [SEGBITS-1:0] p;
    logic [SEGBITS-1:0] g;
    logic [SEGBITS-1:0] s;
    logic [3:0]         pg;
    logic [3:0]         gg;
    logic               c0;
    logic               c1;
    logic               c2;
    logic               c3;
    logic               c4;
    p  = a ^ b;
    g  = a & b;
    s  = {SEGBITS{1'b0}};
    c4 = cin;
    for (int i = 0; i < NUM_GRP; i++) begin
      pg = p[4*i +: 4];
      gg = g[4*i +: 4];
      c0 = c4;
      c1 = gg[0] | (pg[0] & c0);
      c2 = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & c0);
      c3 = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0]) | (pg[2] & pg[1] & pg[0] & c0);
      c4 = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1]) | (pg[3] & pg[2] & pg[1] & gg[0])
         | (pg[3] & pg[2] & pg[1] & pg[0] & c0);
      s[4*i +: 4] = pg ^ {c3, c2, c1, c0};
    end
    return {c4, s};
  endfunction

  logic               adv_s;
  logic [NUMBITS-1:0] b_adj_s;
  logic [SEGBITS:0]   seg0_s;
  logic               fin_vld_s;
  logic [NUMBITS-1:0] fin_res_s;
  logic               fin_cout_s;
  logic               fin_cmsb_s;

  logic               out_valid_r;
  logic [NUMBITS-1:0] result_r;
  logic               carryout_r;
  logic               overflow_r;
  logic               zero_r;

  assign adv_s        = ~out_valid_r | bus.out_ready;
  assign bus.in_ready = adv_s;
  assign b_adj_s      = bus.sub ? ~bus.B : bus.B;
  assign seg0_s       = cla_seg(bus.A[SEGBITS-1:0], b_adj_s[SEGBITS-1:0], bus.carryin);

  // Stage k holds the unprocessed upper operand bits and the k resolved low segments.
  for (genvar k = 1; k < NUM_SEG; k++) begin : g_stg
    localparam int W_HI = NUMBITS - (k * SEGBITS);
    localparam int W_LO = k * SEGBITS;

    logic            vld_r;
    logic [W_HI-1:0] a_hi_r;
    logic [W_HI-1:0] b_hi_r;
    logic [W_LO-1:0] lo_r;
    logic            cy_r;
    logic            vld_s;
    logic [W_HI-1:0] a_hi_s;
    logic [W_HI-1:0] b_hi_s;
    logic [W_LO-1:0] lo_s;
    logic            cy_s;

    if (k == 1) begin : g_first
      assign vld_s  = bus.in_valid;
      assign a_hi_s = bus.A[NUMBITS-1:SEGBITS];
      assign b_hi_s = b_adj_s[NUMBITS-1:SEGBITS];
      assign lo_s   = seg0_s[SEGBITS-1:0];
      assign cy_s   = seg0_s[SEGBITS];
    end else begin : g_next
      logic [SEGBITS:0] seg_s;
      assign seg_s  = cla_seg(g_stg[k-1].a_hi_r[SEGBITS-1:0], g_stg[k-1].b_hi_r[SEGBITS-1:0],
                              g_stg[k-1].cy_r);
      assign vld_s  = g_stg[k-1].vld_r;
      assign a_hi_s = g_stg[k-1].a_hi_r[W_HI+SEGBITS-1:SEGBITS];
      assign b_hi_s = g_stg[k-1].b_hi_r[W_HI+SEGBITS-1:SEGBITS];
      assign lo_s   = {seg_s[SEGBITS-1:0], g_stg[k-1].lo_r};
      assign cy_s   = seg_s[SEGBITS];
    end

    // Stage register: moves with the pipeline, loads data only for valid slots
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        vld_r  <= 1'b0;
        a_hi_r <= {W_HI{1'b0}};
        b_hi_r <= {W_HI{1'b0}};
        lo_r   <= {W_LO{1'b0}};
        cy_r   <= 1'b0;
      end else if (adv_s) begin
        vld_r <= vld_s;
        if (vld_s) begin
          a_hi_r <= a_hi_s;
          b_hi_r <= b_hi_s;
          lo_r   <= lo_s;
          cy_r   <= cy_s;
        end
      end
    end
  end

  // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
  if (NUM_SEG == 1) begin : g_fin_single
    assign fin_vld_s  = bus.in_valid;
    assign fin_res_s  = seg0_s[SEGBITS-1:0];
    assign fin_cout_s = seg0_s[SEGBITS];
    assign fin_cmsb_s = bus.A[NUMBITS-1] ^ b_adj_s[NUMBITS-1] ^ seg0_s[SEGBITS-1];
  end else begin : g_fin_multi
    logic [SEGBITS:0] fin_seg_s;
    assign fin_seg_s  = cla_seg(g_stg[NUM_SEG-1].a_hi_r, g_stg[NUM_SEG-1].b_hi_r,
                                g_stg[NUM_SEG-1].cy_r);
    assign fin_vld_s  = g_stg[NUM_SEG-1].vld_r;
    assign fin_res_s  = {fin_seg_s[SEGBITS-1:0], g_stg[NUM_SEG-1].lo_r};
    assign fin_cout_s = fin_seg_s[SEGBITS];
    assign fin_cmsb_s = g_stg[NUM_SEG-1].a_hi_r[SEGBITS-1] ^ g_stg[NUM_SEG-1].b_hi_r[SEGBITS-1]
                      ^ fin_seg_s[SEGBITS-1];
  end

  // Output stage: flags from the full-width result, held stable while stalled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_r <= 1'b0;
      result_r    <= {NUMBITS{1'b0}};
      carryout_r  <= 1'b0;
      overflow_r  <= 1'b0;
      zero_r      <= 1'b0;
    end else if (adv_s) begin
      out_valid_r <= fin_vld_s;
      if (fin_vld_s) begin
        result_r   <= fin_res_s;
        carryout_r <= fin_cout_s;
        overflow_r <= fin_cmsb_s ^ fin_cout_s;
        zero_r     <= (fin_res_s == {NUMBITS{1'b0}});
      end
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;
  assign bus.carryout  = carryout_r;
  assign bus.overflow  = overflow_r;
  assign bus.zero      = zero_r;
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder: arithmetic reference model with a
// scoreboard on the 32/8 instance, exhaustive 4/4 sweep and a 128/32 spot check.
module tb_pipelined_cla_adder;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  logic [34:0] exp_q[$];

  always #5 clk = ~clk;

  pipelined_cla_adder_if #(.NUMBITS(32))  bus();
  pipelined_cla_adder_if #(.NUMBITS(4))   bus4();
  pipelined_cla_adder_if #(.NUMBITS(128)) bus128();

  pipelined_cla_adder #(.NUMBITS(32),  .SEGBITS(8))  dut    (.clk(clk), .reset(reset), .bus(bus));
  pipelined_cla_adder #(.NUMBITS(4),   .SEGBITS(4))  dut4   (.clk(clk), .reset(reset), .bus(bus4));
  pipelined_cla_adder #(.NUMBITS(128), .SEGBITS(32)) dut128 (.clk(clk), .reset(reset), .bus(bus128));

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: {zero, overflow, carryout, result} from plain integer arithmetic.
  function automatic logic [34:0] model32(input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sub);
    logic [31:0] bb;
    logic [32:0] u;
    longint      t;
    logic        ov;
    bb = sub ? ~b : b;
    u  = {1'b0, a} + {1'b0, bb} + {32'd0, cin};
    t  = longint'($signed(a)) + longint'($signed(bb)) + longint'(cin);
    ov = (t > 64'sd2147483647) || (t < -64'sd2147483648);
    return {(u[31:0] == 32'd0), ov, u[32], u[31:0]};
  endfunction

  function automatic logic [6:0] model4(input logic [3:0] a, input logic [3:0] b,
                                        input logic cin, input logic sub);
    logic [3:0] bb;
    logic [4:0] u;
    int         t;
    logic       ov;
    bb = sub ? ~b : b;
    u  = {1'b0, a} + {1'b0, bb} + {4'd0, cin};
    t  = int'($signed(a)) + int'($signed(bb)) + int'(cin);
    ov = (t > 7) || (t < -8);
    return {(u[3:0] == 4'd0), ov, u[4], u[3:0]};
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  // Scoreboard: every cycle with out_valid the head expectation must be on the outputs.
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
    end else begin
      chk("in_ready", 128'(bus.in_ready), 128'(!bus.out_valid || bus.out_ready));
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: result=%0h appeared, expected no pending op", bus.result);
        end else begin
          chk("sb_result",   128'(bus.result),   128'(exp_q[0][31:0]));
          chk("sb_carryout", 128'(bus.carryout), 128'(exp_q[0][32]));
          chk("sb_overflow", 128'(bus.overflow), 128'(exp_q[0][33]));
          chk("sb_zero",     128'(bus.zero),     128'(exp_q[0][34]));
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model32(bus.A, bus.B, bus.carryin, bus.sub));
    end
  end

  task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
    bit acc;
    int n;
    bus.A = a; bus.B = b; bus.carryin = cin; bus.sub = sub; bus.in_valid = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    chk("send_accept", 128'(acc), 128'(1'b1));
    bus.in_valid = 1'b0;
  endtask

  task automatic run_direct(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic cin, input logic sub, input logic [31:0] er,
                            input logic eco, input logic eov, input logic ez);
    int lat;
    bus.out_ready = 1'b1;
    send32(a, b, cin, sub);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({name, "_latency"},  128'(lat),          128'(4));
    chk({name, "_result"},   128'(bus.result),   128'(er));
    chk({name, "_carryout"}, 128'(bus.carryout), 128'(eco));
    chk({name, "_overflow"}, 128'(bus.overflow), 128'(eov));
    chk({name, "_zero"},     128'(bus.zero),     128'(ez));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0]   v;
    logic [6:0]   m4;
    logic [127:0] wa;
    logic [127:0] wb;
    logic [128:0] ws;
    int           lat;
    int           got[$];
    bit           acc;

    reset = 1'b0;
    bus.in_valid = 1'b0; bus.A = 32'd0; bus.B = 32'd0; bus.carryin = 1'b0; bus.sub = 1'b0;
    bus.out_ready = 1'b1;
    bus4.in_valid = 1'b0; bus4.A = 4'd0; bus4.B = 4'd0; bus4.carryin = 1'b0; bus4.sub = 1'b0;
    bus4.out_ready = 1'b1;
    bus128.in_valid = 1'b0; bus128.A = 128'd0; bus128.B = 128'd0; bus128.carryin = 1'b0;
    bus128.sub = 1'b0; bus128.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(bus.out_valid), 128'(1'b0));
    chk("rst_result",    128'(bus.result),    128'(32'd0));
    chk("rst_carryout",  128'(bus.carryout),  128'(1'b0));
    chk("rst_overflow",  128'(bus.overflow),  128'(1'b0));
    chk("rst_zero",      128'(bus.zero),      128'(1'b0));
    reset = 1'b1;
    #1;
    chk("rst_in_ready", 128'(bus.in_ready), 128'(1'b1));
    @(posedge clk);
    #1;

    // 4-bit exhaustive sweep, single-stage latency: result visible after the accept edge.
    for (int i = 0; i < 1024; i++) begin
      v = 10'(i);
      bus4.A = v[3:0]; bus4.B = v[7:4]; bus4.carryin = v[8]; bus4.sub = v[9]; bus4.in_valid = 1'b1;
      m4 = model4(v[3:0], v[7:4], v[8], v[9]);
      @(posedge clk);
      #1;
      chk("n4_out_valid", 128'(bus4.out_valid), 128'(1'b1));
      chk("n4_result",    128'(bus4.result),    128'(m4[3:0]));
      chk("n4_carryout",  128'(bus4.carryout),  128'(m4[4]));
      chk("n4_overflow",  128'(bus4.overflow),  128'(m4[5]));
      chk("n4_zero",      128'(bus4.zero),      128'(m4[6]));
    end
    bus4.in_valid = 1'b0;

    // 128-bit: all-ones + 1, then one random sum.
    bus128.A = {128{1'b1}}; bus128.B = 128'd1; bus128.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus128.in_valid = 1'b0;
    lat = 1;
    while (!bus128.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("n128_latency",  128'(lat),              128'(4));
    chk("n128_result",   bus128.result,          128'd0);
    chk("n128_carryout", 128'(bus128.carryout),  128'(1'b1));
    chk("n128_zero",     128'(bus128.zero),      128'(1'b1));
    chk("n128_overflow", 128'(bus128.overflow),  128'(1'b0));
    wa = {$urandom(), $urandom(), $urandom(), $urandom()};
    wb = {$urandom(), $urandom(), $urandom(), $urandom()};
    ws = {1'b0, wa} + {1'b0, wb};
    bus128.A = wa; bus128.B = wb; bus128.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus128.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("n128r_valid",    128'(bus128.out_valid), 128'(1'b1));
    chk("n128r_result",   bus128.result,          ws[127:0]);
    chk("n128r_carryout", 128'(bus128.carryout),  128'(ws[128]));

    // Directed corner cases on the 32/8 instance.
    run_direct("t1_wrap",   32'hFFFF_FFFF, 32'd1,         1'b0, 1'b0, 32'd0,         1'b1, 1'b0, 1'b1);
    run_direct("t2_sub_p",  32'd5,         32'd3,         1'b1, 1'b1, 32'd2,         1'b1, 1'b0, 1'b0);
    run_direct("t2_sub_n",  32'd3,         32'd5,         1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run_direct("t3_ovpos",  32'h7FFF_FFFF, 32'd1,         1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    run_direct("t3_ovneg",  32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'd0,         1'b1, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1;

    // Back-to-back ops, 3-cycle stall with a 5th op waiting, then drain in order.
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) send32(32'(i), 32'(i), 1'b0, 1'b0);
    bus.out_ready = 1'b0;
    bus.A = 32'd5; bus.B = 32'd5; bus.carryin = 1'b0; bus.sub = 1'b0; bus.in_valid = 1'b1;
    chk("stall_head_valid", 128'(bus.out_valid), 128'(1'b1));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall_in_ready", 128'(bus.in_ready), 128'(1'b0));
      chk("stall_hold",     128'(bus.result),   128'(32'd2));
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 40 && got.size() < 5; c++) begin
      @(negedge clk);
      if (bus.out_valid) got.push_back(int'(bus.result));
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) bus.in_valid = 1'b0;
    end
    chk("order_count", 128'(got.size()), 128'(5));
    for (int i = 0; i < got.size(); i++) chk("order_value", 128'(got[i]), 128'(2 * (i + 1)));

    // Reset with three ops in flight: nothing from before reset may surface.
    send32(32'd1, 32'd2, 1'b0, 1'b0);
    send32(32'd3, 32'd4, 1'b0, 1'b0);
    send32(32'd5, 32'd6, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 128'(bus.out_valid), 128'(1'b0));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("post_rst_valid",  128'(bus.out_valid), 128'(1'b0));
      chk("post_rst_result", 128'(bus.result),    128'(32'd0));
    end
    @(posedge clk);
    #1;
    run_direct("t5_after_rst", 32'd10, 32'd20, 1'b0, 1'b0, 32'd30, 1'b0, 1'b0, 1'b0);

    // Random traffic with random back-pressure; the scoreboard checks every output.
    acc = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!bus.in_valid || acc) begin
        bus.A = pick32(); bus.B = pick32();
        bus.carryin = 1'($urandom_range(0, 1)); bus.sub = 1'($urandom_range(0, 1));
        bus.in_valid = ($urandom_range(0, 3) != 0);
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(posedge clk);
    #1;
    chk("drain_empty", 128'(exp_q.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
